// File: rtl/mem_stage.sv
// mem_stage: memory-response stage between EX and write-back; holds one instruction and formats load data.
// Optional MEM_LOAD_FWD_EN: forward formatted load data on the bypass in the data_ok cycle.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        left_valid,
    output logic        left_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_addr,
    input  logic        in_wreg_en,
    input  logic [4:0]  in_wreg_index,
    input  logic [2:0]  in_ld_op,
    input  logic        in_st,
    input  logic        in_excp,
    input  logic [15:0] in_excp_num,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    input  logic        flush,
    output logic        right_valid,
    input  logic        right_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_result,
    output logic [31:0] out_mem_addr,
    output logic        out_wreg_en,
    output logic [4:0]  out_wreg_index,
    output logic        out_excp,
    output logic [15:0] out_excp_num,
    output logic        out_llbit_set_en,
    output logic [37:0] mem_bypass,
    output logic        load_pending,
    output logic        mem_busy
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_addr;
    logic [31:0] r_result;
    logic        r_wreg_en;
    logic [4:0]  r_wreg_index;
    logic [2:0]  r_ld_op;
    logic        r_excp;
    logic [15:0] r_excp_num;

    logic        w_is_mem;
    logic        w_accept;
    logic        w_resp;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_wait_result;

    assign w_is_mem   = (in_ld_op != 3'd0 || in_st) && !in_excp;
    assign left_ready = !flush && (r_state == S_EMPTY || (r_state == S_FULL && right_ready));
    assign w_accept   = left_valid && left_ready;
    assign w_resp     = r_state == S_WAIT && data_ok;

    // Alignment uses the held effective address; the response arrives after accept.
    assign w_byte = r_addr[1] ? (r_addr[0] ? rdata[31:24] : rdata[23:16])
                              : (r_addr[0] ? rdata[15:8]  : rdata[7:0]);
    assign w_half = r_addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        w_load_data = r_ld_op == 3'd1 ? {{24{w_byte[7]}}, w_byte} :
                      r_ld_op == 3'd2 ? {{16{w_half[15]}}, w_half} :
                      r_ld_op == 3'd4 ? {24'd0, w_byte} :
                      r_ld_op == 3'd5 ? {16'd0, w_half} : rdata;
        w_wait_result = r_ld_op != 3'd0 ? w_load_data : r_result;
    end

    always_comb begin
        w_next = flush ? (((r_state == S_WAIT || r_state == S_DRAIN) && !data_ok) ? S_DRAIN : S_EMPTY) :
                 w_accept ? (w_is_mem ? S_WAIT : S_FULL) :
                 r_state == S_WAIT  ? (data_ok ? S_FULL : S_WAIT) :
                 r_state == S_FULL  ? (right_ready ? S_EMPTY : S_FULL) :
                 r_state == S_DRAIN ? (data_ok ? S_EMPTY : S_DRAIN) : S_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_EMPTY;
            r_pc         <= '0;
            r_inst       <= '0;
            r_addr       <= '0;
            r_result     <= '0;
            r_wreg_en    <= 1'b0;
            r_wreg_index <= '0;
            r_ld_op      <= '0;
            r_excp       <= 1'b0;
            r_excp_num   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_pc         <= in_pc;
                r_inst       <= in_inst;
                r_addr       <= in_addr;
                r_result     <= in_addr;
                r_wreg_en    <= in_wreg_en;
                r_wreg_index <= in_wreg_index;
                r_ld_op      <= in_ld_op;
                r_excp       <= in_excp;
                r_excp_num   <= in_excp_num;
            end else if (w_resp && !flush) begin
                r_result <= w_wait_result;
            end
        end
    end

    assign right_valid      = r_state == S_FULL;
    assign out_pc           = r_pc;
    assign out_inst         = r_inst;
    assign out_result       = r_result;
    assign out_mem_addr     = r_addr;
    assign out_wreg_en      = r_wreg_en;
    assign out_wreg_index   = r_wreg_index;
    assign out_excp         = r_excp;
    assign out_excp_num     = r_excp_num;
    assign out_llbit_set_en = r_ld_op == 3'd6;
    assign mem_busy         = r_state == S_WAIT || r_state == S_DRAIN;

`ifdef MEM_LOAD_FWD_EN
    assign mem_bypass   = w_resp ? {w_wait_result, r_wreg_index, r_wreg_en}
                                 : {r_result, r_wreg_index, r_wreg_en && r_state == S_FULL};
    assign load_pending = r_state == S_WAIT && r_ld_op != 3'd0 && !data_ok;
`else
    assign mem_bypass   = {r_result, r_wreg_index, r_wreg_en && r_state == S_FULL};
    assign load_pending = r_state == S_WAIT && r_ld_op != 3'd0;
`endif
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-response pipeline stage that sits directly upstream of the write-back stage. It holds one instruction and waits for the data-cache response when that instruction is a load or store. It formats load data by size and alignment, then hands a completed instruction to write-back over a valid/ready handshake. It also drives the register-bypass and load-hazard signals back to decode, and discards stale cache responses after a pipeline flush.

## Interface
Parameters: none.

- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- left_valid  in  1  EX stage presents an instruction
- left_ready  out  1  stage accepts this cycle
- in_pc, in_inst  in  32 each  PC and instruction word
- in_addr  in  32  ALU result, or the effective address for memory operations
- in_wreg_en  in  1  destination write enable
- in_wreg_index  in  5  destination register index
- in_ld_op  in  3  load type: 0 none, 1 ld.b, 2 ld.h, 3 ld.w, 4 ld.bu, 5 ld.hu, 6 ll.w
- in_st  in  1  store; a cache request was issued in EX
- in_excp  in  1  exception already flagged; no cache request was issued
- in_excp_num  in  16  exception vector
- data_ok  in  1  cache response strobe (load data or store acknowledge)
- rdata  in  32  cache load data
- flush  in  1  exception or ertn flush from write-back
- right_valid  out  1  write-back may take the instruction
- right_ready  in  1  write-back accepts
- out_pc, out_inst, out_result, out_mem_addr  out  32 each
- out_wreg_en  out  1
- out_wreg_index  out  5
- out_excp  out  1
- out_excp_num  out  16
- out_llbit_set_en  out  1  high for ll.w
- mem_bypass  out  38  {result[31:0], index[4:0], en}
- load_pending  out  1  load whose data has not yet been forwarded
- mem_busy  out  1  state is WAIT or DRAIN

## Operation
- States:
  - EMPTY: holds nothing.
  - WAIT: outstanding cache access.
  - FULL: result ready for write-back.
  - DRAIN: flushed, waiting to discard an outstanding response.
- Memory operation: (in_ld_op != 0 or in_st) and !in_excp.
- left_ready = !flush and (EMPTY, or FULL with right_ready). It is 0 in WAIT and DRAIN.
- On accept, all fields are latched:
  - memory operation → WAIT;
  - otherwise → FULL, with result = in_addr.
- WAIT with data_ok → FULL. Result:
  - loads: the formatted rdata;
  - stores: in_addr unchanged.
- Load formatting uses in_addr[1:0]:
  - byte loads select rdata[8*a+7:8*a];
  - halfword loads select rdata[16*a[1]+15:16*a[1]];
  - ld.b and ld.h sign-extend; ld.bu and ld.hu zero-extend;
  - ld.w and ll.w pass rdata.
- right_valid = (state == FULL). FULL with right_ready and no new accept → EMPTY.
- FULL with right_ready and left_valid: the old instruction retires and the new one is latched in the same cycle.
- Flush:
  - EMPTY or FULL → EMPTY;
  - WAIT without data_ok → DRAIN;
  - WAIT with data_ok in the same cycle → EMPTY, response discarded.
- DRAIN: data_ok → EMPTY, data discarded. No accept occurs while in DRAIN.
- data_ok is ignored in EMPTY and FULL.
- mem_bypass.en = out_wreg_en and state == FULL. The index and result come from the held fields.
- load_pending = state == WAIT and the held ld_op != 0.
- out_llbit_set_en = held ld_op == 6.
- out_excp and out_excp_num pass through unchanged; this stage raises no exceptions.

## Timing
- Reset (sampled at clk edge with reset = 1): state EMPTY and every output 0. Exception: left_ready = 1 when flush = 0.
- Non-memory instruction: accepted in cycle N; right_valid in N+1.
- Load or store: accepted in N; data_ok is first sampled in N+1. If data_ok arrives in cycle M, right_valid is asserted in M+1.
- Sustained throughput is one instruction per cycle for non-memory traffic with right_ready held at 1.
- Output fields are registered and stay stable while right_valid = 1 and right_ready = 0.

## Configuration
- MEM_LOAD_FWD_EN defined:
  - in WAIT with data_ok = 1, mem_bypass combinationally presents the formatted rdata with en = out_wreg_en;
  - load_pending is 0 in that cycle.
- MEM_LOAD_FWD_EN undefined:
  - bypass is valid only in FULL;
  - load_pending stays 1 through the data_ok cycle.

## Test plan
- ALU op, in_addr = 0x1234, wreg 5, right_ready = 1 → right_valid one cycle later; mem_bypass = {0x1234, 5, 1}; state returns to EMPTY.
- ld.b at addr 0x...3, data_ok two cycles after accept with rdata = 0x80FF_0000 → out_result = 0xFFFF_FF80, right_valid on the following cycle. Repeat with ld.bu → 0x0000_0080.
- ld.h at addr 0x...2 with rdata = 0x8001_0000 → 0xFFFF_8001. ll.w → out_llbit_set_en = 1.
- Flush in WAIT, data_ok three cycles later with rdata = 0xDEAD_BEEF → state DRAIN, left_ready = 0, right_valid never asserted; EMPTY after data_ok; the next load returns its own data.
- FULL with right_ready = 0 for 4 cycles, then 1 with left_valid = 1 → outputs stable throughout the stall; old instruction retires and new one is latched in the same cycle.
- Load with data_ok in cycle M → with MEM_LOAD_FWD_EN, mem_bypass.en = 1 and load_pending = 0 in M; without it, en = 0 and load_pending = 1 in M, and en = 1 in M+1.
